param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/counter_pkg.sv | 14 +
 rtl/tick_gen.sv | 30 +++
 rtl/param_counter.sv | 75 +++++++
 tb/tb_param_counter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the parameterised up/down counter and its prescaler.
package counter_pkg;

    typedef enum logic {
        WRAP     = 1'b0,
        SATURATE = 1'b1
    } counter_mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } counter_state_e;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: raises tick_o on the enabled cycle that completes a PRESCALE interval.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk_4_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // With PRESCALE=1 LAST is zero, so cnt never leaves 0 and tick_o follows en_i.
    assign tick_o = en_i && (cnt == LAST);

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/param_counter.sv
// Up/down counter with prescaled steps, wrap or saturate at terminal, and a DONE hold state.
//   state | meaning
//   RUN   | counting on each prescaled step
//   DONE  | saturated at terminal, count held until load or reset
module param_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH     = 5,
    parameter int               PRESCALE  = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_4_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dir_i,
    input  counter_mode_e    mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             done_o
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    counter_state_e   state;
    logic             tick;
    logic             step;
    logic             at_term;
    logic             next_term;
    logic [WIDTH-1:0] next_cnt;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk_4_i(clk_4_i),
        .rst_ni (rst_ni),
        .en_i   (en_i),
        .clr_i  (load_i),
        .tick_o (tick)
    );

    assign step = tick && !load_i && (state == RUN);

    // Modulo arithmetic gives the wrap values directly: all-ones+1=0, 0-1=all-ones.
    assign next_cnt  = dir_i ? (count_o - 1'b1) : (count_o + 1'b1);
    assign at_term   = dir_i ? (count_o == '0) : (count_o == ALL_ONES);
    assign next_term = dir_i ? (next_cnt == '0) : (next_cnt == ALL_ONES);

    always_ff @(posedge clk_4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_o <= RESET_VAL;
            state   <= RUN;
            tc_o    <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            tc_o <= 1'b0;
            if (load_i) begin
                count_o <= load_val_i;
                state   <= RUN;
                done_o  <= 1'b0;
            end else if (step) begin
                if (at_term && (mode_i == SATURATE)) begin
                    state  <= DONE;
                    done_o <= 1'b1;
                    tc_o   <= 1'b1;
                end else begin
                    count_o <= next_cnt;
                    tc_o    <= !at_term && next_term;
                end
            end
        end
    end

endmodule

// File: tb/tb_param_counter.sv
// Directed bench: two counter instances (PRESCALE=1/RESET_VAL=31 and PRESCALE=4/RESET_VAL=0).
module tb_param_counter;
    import counter_pkg::*;

    logic clk_4_i = 1'b0;
    always #5 clk_4_i = ~clk_4_i;

    logic          rst_a_n = 1'b1, en_a = 1'b0, load_a = 1'b0, dir_a = 1'b1;
    logic [4:0]    load_val_a = '0;
    counter_mode_e mode_a = WRAP;
    logic [4:0]    count_a;
    logic          tc_a, done_a;

    logic          rst_b_n = 1'b1, en_b = 1'b0, load_b = 1'b0, dir_b = 1'b0;
    logic [4:0]    load_val_b = '0;
    counter_mode_e mode_b = WRAP;
    logic [4:0]    count_b;
    logic          tc_b, done_b;

    int n_cmp = 0;
    int n_err = 0;

    param_counter #(.WIDTH(5), .PRESCALE(1), .RESET_VAL(5'd31)) dut_a (
        .clk_4_i(clk_4_i), .rst_ni(rst_a_n), .en_i(en_a), .load_i(load_a),
        .load_val_i(load_val_a), .dir_i(dir_a), .mode_i(mode_a),
        .count_o(count_a), .tc_o(tc_a), .done_o(done_a)
    );

    param_counter #(.WIDTH(5), .PRESCALE(4), .RESET_VAL(5'd0)) dut_b (
        .clk_4_i(clk_4_i), .rst_ni(rst_b_n), .en_i(en_b), .load_i(load_b),
        .load_val_i(load_val_b), .dir_i(dir_b), .mode_i(mode_b),
        .count_o(count_b), .tc_o(tc_b), .done_o(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_4_i);
    endtask

    task automatic chk_a(input string tag, input int c, input bit tc, input bit dn);
        chk({tag, ".count"}, 32'(count_a), 32'(c));
        chk({tag, ".tc"},    32'(tc_a),    32'(tc));
        chk({tag, ".done"},  32'(done_a),  32'(dn));
    endtask

    task automatic chk_b(input string tag, input int c, input bit tc, input bit dn);
        chk({tag, ".count"}, 32'(count_b), 32'(c));
        chk({tag, ".tc"},    32'(tc_b),    32'(tc));
        chk({tag, ".done"},  32'(done_b),  32'(dn));
    endtask

    initial begin
        #1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        tick(1);
        chk_a("a_reset", 31, 0, 0);
        chk_b("b_reset", 0, 0, 0);

        // Instance A: down, WRAP, from RESET_VAL=31
        en_a = 1'b1; dir_a = 1'b1; mode_a = WRAP;
        rst_a_n = 1'b1;
        tick(1);  chk_a("a_first_step", 30, 0, 0);
        en_a = 1'b0;
        tick(1);  chk_a("a_en_low_hold", 30, 0, 0);
        en_a = 1'b1;
        tick(29); chk_a("a_at_1", 1, 0, 0);
        tick(1);  chk_a("a_at_0_tc", 0, 1, 0);
        tick(1);  chk_a("a_wrap_down", 31, 0, 0);

        // Load to terminal gives no tc; flipping dir before the step counts down
        load_a = 1'b1; load_val_a = 5'd31; dir_a = 1'b0;
        tick(1);  chk_a("a_load31_no_tc", 31, 0, 0);
        load_a = 1'b0; dir_a = 1'b1;
        tick(1);  chk_a("a_dir_flip", 30, 0, 0);
        dir_a = 1'b0;
        tick(1);  chk_a("a_up_to_31_tc", 31, 1, 0);
        tick(1);  chk_a("a_wrap_up", 0, 0, 0);

        // SATURATE down from 3
        mode_a = SATURATE; dir_a = 1'b1; load_a = 1'b1; load_val_a = 5'd3;
        tick(1);  chk_a("a_sat_load3", 3, 0, 0);
        load_a = 1'b0;
        tick(1);  chk_a("a_sat_2", 2, 0, 0);
        tick(1);  chk_a("a_sat_1", 1, 0, 0);
        tick(1);  chk_a("a_sat_0_tc", 0, 1, 0);
        tick(1);  chk_a("a_sat_done_tc", 0, 1, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1); chk_a("a_sat_hold", 0, 0, 1);
        end
        mode_a = WRAP; dir_a = 1'b0;
        tick(2);  chk_a("a_done_ignores_mode_dir", 0, 0, 1);
        load_a = 1'b1; load_val_a = 5'd7;
        tick(1);  chk_a("a_load7_exit_done", 7, 0, 0);
        load_a = 1'b0; en_a = 1'b0;

        // Instance B: PRESCALE=4, up, WRAP, from reset
        en_b = 1'b1;
        rst_b_n = 1'b1;
        tick(3);  chk_b("b_3_edges", 0, 0, 0);
        tick(1);  chk_b("b_4_edges", 1, 0, 0);
        tick(3);  chk_b("b_7_edges", 1, 0, 0);
        tick(1);  chk_b("b_8_edges", 2, 0, 0);
        tick(12); chk_b("b_20_edges", 5, 0, 0);

        // Load mid-interval restarts the prescaler
        tick(2);  chk_b("b_mid_interval", 5, 0, 0);
        load_b = 1'b1; load_val_b = 5'd9;
        tick(1);  chk_b("b_load9", 9, 0, 0);
        load_b = 1'b0;
        tick(3);  chk_b("b_load_plus3", 9, 0, 0);
        tick(1);  chk_b("b_load_plus4", 10, 0, 0);

        // Async reset between edges at count 12
        load_b = 1'b1; load_val_b = 5'd12;
        tick(1);  chk_b("b_load12", 12, 0, 0);
        load_b = 1'b0;
        tick(1);
        #2 rst_b_n = 1'b0;
        #1 chk_b("b_async_reset", 0, 0, 0);
        tick(1);
        rst_b_n = 1'b1;
        tick(2);  chk_b("b_post_reset_2", 0, 0, 0);
        en_b = 1'b0;
        tick(3);  chk_b("b_en_low_freeze", 0, 0, 0);
        en_b = 1'b1;
        tick(1);  chk_b("b_post_reset_3", 0, 0, 0);
        tick(1);  chk_b("b_post_reset_4", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
